// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Imported by the fetch top and its PC register.
package rv_fetch_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    DRAIN,
    HOLD,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } if_id_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset, redirect load, +4 on consume.
// Flags a redirect target that is not word aligned.
module fetch_pc_reg
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic            inc,
  output logic [XLEN-1:0] pc,
  output logic            misalign
);

  assign misalign = load && (load_pc[1:0] != 2'b00);

  // Redirect wins over increment; a faulting target is still recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + XLEN'(PC_STEP);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem request,
// valid/ready output, redirect with stale-response drop.
module inst_fetch
  import rv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = rv_fetch_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic [24:0]     imm_field,
  output logic            fetch_fault
);

  fetch_state_t    state;
  if_id_t          held;
  logic            pend;
  logic [XLEN-1:0] pc;
  logic            misalign;
  logic            accept;
  logic            resp;
  logic            consume;
  logic            pend_after;

  assign imem_req_valid = (state == REQ) && !rst;
  assign imem_addr      = pc;

  assign accept     = imem_req_valid && imem_req_ready;
  assign resp       = imem_resp_valid && pend;
  assign consume    = (state == HOLD) && inst_ready
                      && !redirect_valid;
  assign pend_after = accept || (pend && !imem_resp_valid);

  assign inst_out  = held.inst;
  assign inst_pc   = held.pc;
  assign imm_field = held.inst[31:7];

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (redirect_valid),
    .load_pc  (redirect_pc),
    .inc      (consume),
    .pc       (pc),
    .misalign (misalign)
  );

  // Fetch control: redirect overrides all, pend tracks the one
  // outstanding request so late responses are absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pend        <= 1'b0;
      inst_valid  <= 1'b0;
      held        <= '{inst: NOP_INST, pc: RESET_PC};
      fetch_fault <= 1'b0;
    end else begin
      pend <= pend_after;
      if (redirect_valid) begin
        inst_valid <= 1'b0;
        if (misalign) begin
          fetch_fault <= 1'b1;
          state       <= FAULT;
        end else begin
          fetch_fault <= 1'b0;
          state       <= pend_after ? DRAIN : REQ;
        end
      end else begin
        unique case (state)
          REQ: begin
            if (accept) state <= WAIT;
          end
          WAIT: begin
            if (resp) begin
              held       <= '{inst: imem_resp_data, pc: pc};
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end
          HOLD: begin
            if (inst_ready) begin
              inst_valid <= 1'b0;
              state      <= REQ;
            end
          end
          DRAIN: begin
            if (resp) state <= REQ;
          end
          FAULT: begin
            state <= FAULT;
          end
          default: begin
            state <= REQ;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: request and instruction
// queues checked by a memory model and an output monitor.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [24:0] imm_field;
  logic        fetch_fault;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_q[$];
  int          checks = 0;
  int          errors = 0;
  int          lat    = 1;

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_out        (inst_out),
    .inst_pc         (inst_pc),
    .imm_field       (imm_field),
    .fetch_fault     (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h00F0_0193;
      32'h0000_000C: return 32'hDEAD_BEEF;
      32'h0000_0040: return 32'h0400_0293;
      32'h0000_0044: return 32'hBAD0_0044;
      32'h0000_0100: return 32'h1000_0213;
      32'h0000_0200: return 32'h2000_0313;
      32'h0000_0204: return 32'hBAD0_0204;
      32'h0000_0300: return 32'h3000_0393;
      32'hFFFF_FFFC: return 32'h7FF0_0413;
      default:       return 32'hBAD0_BAD0;
    endcase
  endfunction

  task automatic push_req(input logic [31:0] a);
    req_q.push_back(a);
  endtask

  task automatic push_inst(input logic [31:0] i,
                           input logic [31:0] p);
    exp_t e;
    e.inst = i;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_pc(input logic [31:0] p, input int budget);
    int n = 0;
    while (!(inst_valid === 1'b1 && inst_pc === p) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_pc: inst_valid=%b inst_pc=%h expected pc %h",
               inst_valid, inst_pc, p);
    end
  endtask

  // Memory model: variable latency, one response per accept.
  initial begin
    logic        busy;
    int          cnt;
    logic [31:0] cur;
    busy = 1'b0;
    cnt  = 0;
    cur  = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(cur);
            busy = 1'b0;
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          checks++;
          if (busy) begin
            errors++;
            $display("FAIL overlap: addr %h accepted while busy",
                     imem_addr);
          end
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_unexpected: got %h expected none",
                     imem_addr);
          end else begin
            chk("req_addr", imem_addr, req_q.pop_front());
          end
          busy = 1'b1;
          cnt  = lat;
          cur  = imem_addr;
        end
      end
    end
  end

  // Output monitor: pop on each new presentation, then hold stable.
  initial begin
    logic prev;
    exp_t last;
    prev = 1'b0;
    last.inst = '0;
    last.pc   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (inst_valid === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL inst_unexpected: got %h at pc %h expected none",
                   inst_out, inst_pc);
        end else begin
          last = exp_q.pop_front();
          chk("inst_out", inst_out, last.inst);
          chk("inst_pc", inst_pc, last.pc);
          chk("imm_field", {7'd0, imm_field}, {7'd0, last.inst[31:7]});
        end
      end else if (inst_valid === 1'b1 && prev) begin
        chk("hold_inst", inst_out, last.inst);
        chk("hold_pc", inst_pc, last.pc);
      end
      prev = (inst_valid === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat            = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_out", inst_out, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

    // First fetch after reset
    @(negedge clk);
    push_req(32'h0);
    push_inst(32'h0050_0093, 32'h0);
    rst = 1'b0;
    wait_pc(32'h0, 10);
    chk("first_imm", {7'd0, imm_field}, 32'h0000_A001);

    // Sequential fetches with ready held high
    push_req(32'h4);
    push_inst(32'h00A0_0113, 32'h4);
    push_req(32'h8);
    push_inst(32'h00F0_0193, 32'h8);
    inst_ready = 1'b1;
    wait_pc(32'h8, 20);
    inst_ready = 1'b0;

    // Backpressure in HOLD
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_inst_pc", inst_pc, 32'h8);
    end

    // Redirect to 0x40 coincident with ready in HOLD
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    inst_ready     = 1'b1;
    push_req(32'h40);
    push_inst(32'h0400_0293, 32'h40);
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    wait_pc(32'h40, 20);

    // Redirect to 0x100 in WAIT, stale response 3 cycles later
    lat        = 4;
    inst_ready = 1'b1;
    push_req(32'h44);
    push_req(32'h100);
    push_inst(32'h1000_0213, 32'h100);
    @(negedge clk);
    inst_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    lat            = 1;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pc(32'h100, 30);

    // Misaligned redirect, then recovery
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("flt_fault", {31'd0, fetch_fault}, 32'd1);
      chk("flt_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("flt_inst_valid", {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
    end
    push_req(32'h200);
    push_inst(32'h2000_0313, 32'h200);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("flt_clear", {31'd0, fetch_fault}, 32'd0);
    wait_pc(32'h200, 20);

    // Fault with a response still outstanding
    lat        = 4;
    inst_ready = 1'b1;
    push_req(32'h204);
    @(negedge clk);
    inst_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h301;
    @(negedge clk);
    redirect_pc = 32'h300;
    push_req(32'h300);
    push_inst(32'h3000_0393, 32'h300);
    lat = 1;
    #1;
    chk("pend_fault", {31'd0, fetch_fault}, 32'd1);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("pend_clear", {31'd0, fetch_fault}, 32'd0);
    chk("pend_drain_req", {31'd0, imem_req_valid}, 32'd0);
    wait_pc(32'h300, 20);

    // PC wrap from 0xFFFF_FFFC
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    push_req(32'hFFFF_FFFC);
    push_inst(32'h7FF0_0413, 32'hFFFF_FFFC);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_pc(32'hFFFF_FFFC, 20);
    push_req(32'h0);
    push_inst(32'h0050_0093, 32'h0);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    wait_pc(32'h0, 20);

    // Reset mid-operation
    inst_ready = 1'b1;
    @(negedge clk);
    rst        = 1'b1;
    inst_ready = 1'b0;
    #1;
    chk("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mid_rst_inst_out", inst_out, 32'h0000_0013);
    chk("mid_rst_inst_pc", inst_pc, 32'h0);
    chk("mid_rst_fault", {31'd0, fetch_fault}, 32'd0);
    @(negedge clk);
    push_req(32'h0);
    push_inst(32'h0050_0093, 32'h0);
    rst = 1'b0;
    wait_pc(32'h0, 10);

    repeat (3) @(negedge clk);
    chk("inst_q_empty", exp_q.size(), 32'd0);
    chk("req_q_empty", req_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
